axi4_mem_master: RTL and testbench



---
 rtl/axi_mem_pkg.sv | 32 +++
 rtl/axi_phase_watchdog.sv | 46 ++++
 rtl/axi4_mem_master.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4_mem_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the command-to-AXI memory master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the bus widths of the 32x16 memory slave, the master FSM state
// encoding and the response codes returned on the command side.
package axi_mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    // States in which the master is waiting on the slave and may stall.
    function automatic logic phase_is_guarded(input state_t s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == WR_RESP) ||
               (s == RD_ADDR) || (s == RD_DATA);
    endfunction

endpackage

// File: rtl/axi_phase_watchdog.sv
// Per-phase stall watchdog: counts cycles spent in a guarded phase.
// Latency: expired is combinational from the count; it is high in the last allowed cycle.
// Backpressure: none; the counter saturates and never wraps.
//
// Ports: clk, reset_n (async active-low), clear (phase entry), enable (guarded
// phase active), expired (the count reaches TIMEOUT_CYCLES at the next edge).
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module axi_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires in the cycle whose closing edge would bring the count to
    // TIMEOUT_CYCLES, so a stalled VALID is held for exactly TIMEOUT_CYCLES cycles.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/axi4_mem_master.sv
// Command-to-AXI master: one read/write command in, AW->W->B or AR->R out, one response back.
// Latency: write >= 5 cycles, read >= 4 cycles from command accept to RSP_VALID (all outputs registered).
// Backpressure: CMD_READY only in IDLE; response held until RSP_READY; stalled phases abort with code 11.
//
// Ports: clk/reset_n; cmd_* command port; rsp_* response port; a_w_*, w_*, b_*
// write channels; a_r_*, r_*, rrsep read channels. B_READY/R_READY are raised
// only after the matching VALID has been seen, for exactly one cycle.
module axi4_mem_master
    import axi_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_code,
    output logic [ADDR_W-1:0] a_w_addr,
    output logic              a_w_valid,
    input  logic              a_w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    input  logic              b_valid,
    input  logic [1:0]        b_resp,
    output logic              b_ready,
    output logic [ADDR_W-1:0] a_r_addr,
    output logic              a_r_valid,
    input  logic              a_r_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic              rrsep,
    output logic              r_ready
);

    state_t              state_q,     state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                aw_valid_q,  aw_valid_d;
    logic                w_valid_q,   w_valid_d;
    logic                b_ready_q,   b_ready_d;
    logic                ar_valid_q,  ar_valid_d;
    logic                r_ready_q,   r_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_code_q,  rsp_code_d;

    logic wd_clear;
    logic wd_expired;
    logic timeout_hit;

    axi_phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (phase_is_guarded(state_q)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_code_d  = rsp_code_q;
        timeout_hit = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_write ? cmd_wdata : '0;
                    rsp_rdata_d = '0;
                    rsp_code_d  = RSP_OK;
                    if (cmd_write) begin
                        state_d    = WR_ADDR;
                        aw_valid_d = 1'b1;
                    end else begin
                        state_d    = RD_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (a_w_ready) begin
                    aw_valid_d = 1'b0;
                    w_valid_d  = 1'b1;
                    state_d    = WR_DATA;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            WR_DATA: begin
                if (w_ready) begin
                    w_valid_d = 1'b0;
                    state_d   = WR_RESP;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            WR_RESP: begin
                // First pass sees B_VALID and raises B_READY; the second pass
                // is the handshake cycle itself.
                if (b_ready_q) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (b_valid) begin
                    b_ready_d  = 1'b1;
                    rsp_code_d = (b_resp == 2'b00) ? RSP_OK : RSP_SLVERR;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            RD_ADDR: begin
                if (a_r_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_DATA;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_ready_q) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (r_valid) begin
                    r_ready_d   = 1'b1;
                    rsp_rdata_d = r_data;
                    rsp_code_d  = rrsep ? RSP_SLVERR : RSP_OK;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled phase releases every AXI VALID/READY on the same edge.
        if (timeout_hit) begin
            aw_valid_d  = 1'b0;
            w_valid_d   = 1'b0;
            b_ready_d   = 1'b0;
            ar_valid_d  = 1'b0;
            r_ready_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_TIMEOUT;
            rsp_rdata_d = '0;
            state_d     = RESP;
        end
    end

    assign wd_clear = (state_d != state_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= RSP_OK;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_code  = rsp_code_q;
    assign a_w_addr  = addr_q;
    assign a_w_valid = aw_valid_q;
    assign w_data    = wdata_q;
    assign w_valid   = w_valid_q;
    assign b_ready   = b_ready_q;
    assign a_r_addr  = addr_q;
    assign a_r_valid = ar_valid_q;
    assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_axi4_mem_master.sv
// Bench for axi4_mem_master paired with a small 32x16 AXI memory slave model.
// Latency: n/a.
// Backpressure: slave channel readies are steerable to create stalls.
module tb_axi4_mem_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_code;
    logic [4:0]  a_w_addr, a_r_addr;
    logic        a_w_valid, a_w_ready, w_valid, w_ready;
    logic [15:0] w_data, r_data;
    logic        b_valid, b_ready, a_r_valid, a_r_ready, r_valid, rrsep, r_ready;
    logic [1:0]  b_resp;

    // Slave steering knobs.
    logic        aw_en, w_en, ar_en;
    logic [1:0]  slv_resp;
    logic [15:0] mem [32];
    logic [4:0]  wa;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_mem_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
        .a_w_addr(a_w_addr), .a_w_valid(a_w_valid), .a_w_ready(a_w_ready),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
        .a_r_addr(a_r_addr), .a_r_valid(a_r_valid), .a_r_ready(a_r_ready),
        .r_valid(r_valid), .r_data(r_data), .rrsep(rrsep), .r_ready(r_ready)
    );

    // ---------------- memory slave model ----------------
    assign a_w_ready = aw_en;
    assign w_ready   = w_en;
    assign a_r_ready = ar_en;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_valid <= 1'b0;
            b_resp  <= 2'b00;
            r_valid <= 1'b0;
            r_data  <= 16'h0;
            rrsep   <= 1'b0;
            wa      <= 5'd0;
            for (int k = 0; k < 32; k++) mem[k] <= 16'h0;
        end else begin
            if (a_w_valid && a_w_ready) wa <= a_w_addr;
            if (b_valid && b_ready) begin
                b_valid <= 1'b0;
            end else if (w_valid && w_ready) begin
                mem[wa] <= w_data;
                b_valid <= 1'b1;
                b_resp  <= slv_resp;
            end
            if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end else if (a_r_valid && a_r_ready) begin
                r_valid <= 1'b1;
                r_data  <= mem[a_r_addr];
                rrsep   <= |slv_resp;
            end
        end
    end

    // ---------------- handshake monitor ----------------
    int cyc = 0;
    int n_rready = 0;
    int n_arv = 0;
    int acc_addr_q[$];
    int acc_cyc_q[$];
    int rsp_cyc_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cmd_valid && cmd_ready) begin
            acc_addr_q.push_back(int'(cmd_addr));
            acc_cyc_q.push_back(cyc);
        end
        if (rsp_valid && rsp_ready) rsp_cyc_q.push_back(cyc);
        if (r_ready)   n_rready = n_rready + 1;
        if (a_r_valid) n_arv    = n_arv + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [15:0] d,
                          output logic [1:0] code, output logic [15:0] rd, output logic ok);
        int n;
        ok   = 1'b1;
        code = 2'b00;
        rd   = 16'h0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            bound_fail("cmd_accept");
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            bound_fail("rsp_wait");
            ok = 1'b0;
            return;
        end
        code = rsp_code;
        rd   = rsp_rdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  slv_resp;
        logic [1:0]  exp_code;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  code;
        logic [15:0] rd;
        logic        ok;
        int          rr0, arv0, a0, r0, n, stable_bad;

        vecs[0] = '{1'b1, 5'd5,  16'hBEEF, 2'b00, 2'b00, 16'h0000};
        vecs[1] = '{1'b0, 5'd5,  16'h0000, 2'b00, 2'b00, 16'hBEEF};
        vecs[2] = '{1'b1, 5'd7,  16'hA5A5, 2'b01, 2'b10, 16'h0000};
        vecs[3] = '{1'b0, 5'd7,  16'h0000, 2'b10, 2'b10, 16'hA5A5};
        vecs[4] = '{1'b0, 5'd12, 16'h0000, 2'b00, 2'b00, 16'h0000};
        vecs[5] = '{1'b1, 5'd12, 16'h0F0F, 2'b00, 2'b00, 16'h0000};
        vecs[6] = '{1'b0, 5'd12, 16'h0000, 2'b00, 2'b00, 16'h0F0F};
        vecs[7] = '{1'b0, 5'd31, 16'h0000, 2'b00, 2'b00, 16'h0000};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 5'd0;
        cmd_wdata = 16'h0;
        rsp_ready = 1'b0;
        aw_en = 1'b1; w_en = 1'b1; ar_en = 1'b1;
        slv_resp = 2'b00;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {cmd_ready, a_w_valid, w_valid, b_ready, a_r_valid, r_ready, rsp_valid,
             rsp_code, rsp_rdata, a_w_addr, w_data, a_r_addr}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Table-driven single commands.
        for (int i = 0; i < 8; i++) begin
            slv_resp = vecs[i].slv_resp;
            rr0 = n_rready;
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, code, rd, ok);
            if (ok) begin
                chk($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rready_cycles", i), n_rready - rr0, vecs[i].wr ? 0 : 1);
                chk($sformatf("vec%0d_rsp_dropped", i), rsp_valid, 0);
                chk($sformatf("vec%0d_cmd_ready_back", i), cmd_ready, 1);
            end
        end
        slv_resp = 2'b00;
        chk("mem5_written", mem[5], 16'hBEEF);
        chk("mem12_written", mem[12], 16'h0F0F);

        // Back-to-back writes with CMD_VALID held high.
        a0 = acc_addr_q.size();
        r0 = rsp_cyc_q.size();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd31; cmd_wdata = 16'hAAAA;
        rsp_ready = 1'b1;
        n = 0;
        while (acc_addr_q.size() < a0 + 1 && n < 50) begin @(negedge clk); n++; end
        cmd_addr = 5'd0; cmd_wdata = 16'h5555;
        n = 0;
        while (acc_addr_q.size() < a0 + 2 && n < 100) begin @(negedge clk); n++; end
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_cyc_q.size() < r0 + 2 && n < 100) begin @(negedge clk); n++; end
        rsp_ready = 1'b0;
        if (acc_addr_q.size() == a0 + 2 && rsp_cyc_q.size() == r0 + 2) begin
            chk("b2b_first_addr", acc_addr_q[a0], 31);
            chk("b2b_second_addr", acc_addr_q[a0 + 1], 0);
            chk("b2b_accept_after_rsp", acc_cyc_q[a0 + 1], rsp_cyc_q[r0] + 1);
            chk("b2b_mem31", mem[31], 16'hAAAA);
            chk("b2b_mem0", mem[0], 16'h5555);
        end else begin
            bound_fail("b2b_complete");
        end

        // Read address channel never accepts -> watchdog.
        ar_en = 1'b0;
        arv0 = n_arv;
        rr0  = n_rready;
        do_cmd(1'b0, 5'd3, 16'h0, code, rd, ok);
        ar_en = 1'b1;
        if (ok) begin
            chk("timeout_code", code, 2'b11);
            chk("timeout_rdata", rd, 16'h0);
            chk("timeout_arvalid_cycles", n_arv - arv0, 16);
            chk("timeout_arvalid_low", a_r_valid, 0);
            chk("timeout_no_rready", n_rready - rr0, 0);
            chk("timeout_back_idle", cmd_ready, 1);
        end

        // Response held off for 10 cycles; stray commands must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp_valid) bound_fail("stall_rsp_wait");
        a0 = acc_addr_q.size();
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_rdata !== 16'hBEEF || rsp_code !== 2'b00) stable_bad++;
            cmd_valid = (i % 2 == 0);
            cmd_write = 1'b1; cmd_addr = 5'd2; cmd_wdata = 16'h1234;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("stall_payload_stable", stable_bad, 0);
        chk("stall_rdata_hold", rsp_rdata, 16'hBEEF);
        chk("stall_no_accept", acc_addr_q.size(), a0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_rsp_done", rsp_valid, 0);
        chk("stall_mem2_untouched", mem[2], 16'h0);

        // Reset asserted while parked in WR_DATA.
        w_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd9; cmd_wdata = 16'h1111;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!w_valid && n < 10) begin @(negedge clk); n++; end
        if (!w_valid) bound_fail("reset_wait_wvalid");
        r0 = rsp_cyc_q.size();
        #2 reset_n = 1'b0;
        #1;
        chk("reset_async_wvalid", w_valid, 0);
        chk("reset_async_cmd_ready", cmd_ready, 0);
        chk("reset_async_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        w_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_no_rsp", rsp_cyc_q.size(), r0);
        chk("reset_rsp_valid_low", rsp_valid, 0);
        chk("reset_cmd_ready_back", cmd_ready, 1);
        do_cmd(1'b1, 5'd9, 16'h2222, code, rd, ok);
        if (ok) chk("post_reset_write_code", code, 2'b00);
        do_cmd(1'b0, 5'd9, 16'h0, code, rd, ok);
        if (ok) begin
            chk("post_reset_read_code", code, 2'b00);
            chk("post_reset_read_data", rd, 16'h2222);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
